// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - request/data and SPI pin bundle for spi_master
// Ports:
//   en_transit  transfer request (sampled by the master only while idle)
//   data[7:0]   byte to send, captured when the transfer starts
//   sck         SPI clock, mode 0 (idle low)
//   mosi        serial data out, MSB first
//   cs          active-low chip select
//   busy        high whenever the master is not idle
// Modports: master = the spi_master block, slave = the requester / pin observer.
interface spi_master_if;
  logic       en_transit;
  logic [7:0] data;
  logic       sck;
  logic       mosi;
  logic       cs;
  logic       busy;

  modport master (
    input  en_transit,
    input  data,
    output sck,
    output mosi,
    output cs,
    output busy
  );

  modport slave (
    output en_transit,
    output data,
    input  sck,
    input  mosi,
    input  cs,
    input  busy
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte SPI mode-0 master with programmable SCK divider
// Parameters:
//   CLK_DIV  SCK half-period in clk cycles (1..255)
// Ports:
//   clk      system clock, all state changes on the rising edge
//   reset    asynchronous active-low reset, aborts any transfer
//   bus      spi_master_if.master: en_transit/data in, sck/mosi/cs/busy out
// Every output is a flop; nothing combinational reaches the pins.
module spi_master #(
  parameter int CLK_DIV = 1
) (
  input  logic          clk,
  input  logic          reset,
  spi_master_if.master  bus
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    TRANSFER,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] div_q, div_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       cs_q, cs_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= 8'd0;
      bitcnt_q <= 3'd0;
      div_q    <= 8'd0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      div_q    <= div_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    div_d    = div_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (bus.en_transit) begin
          shreg_d  = bus.data;
          mosi_d   = bus.data[7];
          cs_d     = 1'b0;
          busy_d   = 1'b1;
          bitcnt_d = 3'd0;
          div_d    = 8'd0;
          state_d  = TRANSFER;
        end
      end
      TRANSFER: begin
        if (div_q == DIV_MAX) begin
          div_d = 8'd0;
          sck_d = ~sck_q;
          // sck_q high means this toggle is a falling edge: advance the data bit
          if (sck_q) begin
            if (bitcnt_q == 3'd7) begin
              state_d = DONE;
            end else begin
              // Rotate rather than shift so the register keeps every bit live;
              // bit 6 is always the next bit to present.
              mosi_d   = shreg_q[6];
              shreg_d  = {shreg_q[6:0], shreg_q[7]};
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        // Hold cs low one more half-period after the last falling edge
        if (div_q == DIV_MAX) begin
          div_d   = 8'd0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.cs   = cs_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master at CLK_DIV=1 and CLK_DIV=4
module tb_spi_master;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_master_if bus0 ();
  spi_master_if bus1 ();

  spi_master #(.CLK_DIV(1)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
  spi_master #(.CLK_DIV(4)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected mosi bits per DUT, pushed at request time
  logic q0[$];
  logic q1[$];

  int   divs[2]      = '{1, 4};
  int   off[2]       = '{0, 0};
  int   rises[2]     = '{0, 0};
  int   last_chg[2]  = '{0, 0};
  int   last_rise[2] = '{0, 0};
  int   total[2]     = '{0, 0};
  logic psck[2]      = '{1'b0, 1'b0};
  logic pcs[2]       = '{1'b1, 1'b1};
  logic pmosi[2]     = '{1'b0, 1'b0};

  task automatic mon_step(input int i, input logic s, input logic m, input logic c, input logic b);
    logic e;
    if (c == 1'b0) begin
      if (pcs[i]) begin
        off[i] = 0; rises[i] = 0; last_chg[i] = 0; last_rise[i] = -1000;
      end else begin
        off[i]++;
        if (m !== pmosi[i]) begin
          last_chg[i] = off[i];
          check("mosi_hold", off[i] - last_rise[i], divs[i]);
        end
      end
      if (s && !psck[i]) begin
        rises[i]++;
        total[i]++;
        last_rise[i] = off[i];
        check("sck_rise_pos", off[i], divs[i] * (2 * rises[i] - 1));
        check("mosi_setup", 32'((off[i] - last_chg[i]) >= divs[i]), 1);
        check("busy_in_frame", b, 1);
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          check("extra_sck_rise", 1, 0);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check("mosi_bit", m, e);
        end
      end
    end else if (!pcs[i]) begin
      check("cs_low_len", off[i] + 1, 17 * divs[i]);
      check("sck_rises", rises[i], 8);
      check("end_mosi", m, 0);
      check("end_busy", b, 0);
    end
    psck[i]  = s;
    pcs[i]   = c;
    pmosi[i] = m;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      psck  = '{1'b0, 1'b0};
      pcs   = '{1'b1, 1'b1};
      pmosi = '{1'b0, 1'b0};
    end else begin
      mon_step(0, bus0.sck, bus0.mosi, bus0.cs, bus0.busy);
      mon_step(1, bus1.sck, bus1.mosi, bus1.cs, bus1.busy);
    end
  end

  task automatic start(input int i, input logic [7:0] d);
    @(negedge clk);
    if (i == 0) begin
      bus0.data = d; bus0.en_transit = 1'b1;
      for (int b = 7; b >= 0; b--) q0.push_back(d[b]);
    end else begin
      bus1.data = d; bus1.en_transit = 1'b1;
      for (int b = 7; b >= 0; b--) q1.push_back(d[b]);
    end
    @(posedge clk);
    #1;
    if (i == 0) bus0.en_transit = 1'b0;
    else        bus1.en_transit = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int   k;
    logic idle;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      idle = (i == 0) ? (bus0.cs && !bus0.busy) : (bus1.cs && !bus1.busy);
    end while (!idle && k < 2000);
    check("idle_timeout", idle, 1);
  endtask

  initial begin
    int t0;
    int h;
    bus0.en_transit = 1'b0; bus0.data = 8'h00;
    bus1.en_transit = 1'b0; bus1.data = 8'h00;
    #12;
    check("rst_cs", bus0.cs, 1);
    check("rst_sck", bus0.sck, 0);
    check("rst_mosi", bus0.mosi, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_cs_div4", bus1.cs, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte
    start(0, 8'hAA);
    wait_idle(0);

    // Request while busy is dropped
    start(0, 8'hAA);
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus0.en_transit = 1'b1;
    @(posedge clk);
    #1;
    bus0.en_transit = 1'b0;
    wait_idle(0);
    repeat (5) @(negedge clk);
    check("ignored_req_cs", bus0.cs, 1);
    check("ignored_req_busy", bus0.busy, 0);

    // Data change after capture
    start(0, 8'h3C);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus0.data = 8'hFF;
    wait_idle(0);

    // Continuous request: two frames, one-cycle cs gap
    @(negedge clk);
    bus0.data = 8'h81; bus0.en_transit = 1'b1;
    for (int b = 7; b >= 0; b--) q0.push_back(bus0.data[b]);
    @(posedge clk);
    h = 0;
    do begin @(negedge clk); h++; end while (bus0.cs == 1'b0 && h < 100);
    for (int b = 7; b >= 0; b--) q0.push_back(bus0.data[b]);
    h = 1;
    @(negedge clk);
    while (bus0.cs == 1'b1 && h < 100) begin h++; @(negedge clk); end
    check("cs_gap", h, 1);
    bus0.en_transit = 1'b0;
    wait_idle(0);

    // Divided clock
    start(1, 8'h5A);
    wait_idle(1);

    // Reset mid-transfer
    start(0, 8'hAA);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_cs", bus0.cs, 1);
    check("async_rst_sck", bus0.sck, 0);
    check("async_rst_mosi", bus0.mosi, 0);
    check("async_rst_busy", bus0.busy, 0);
    q0.delete();
    t0 = total[0];
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_cs", bus0.cs, 1);
    check("post_rst_rises", total[0], t0);
    start(0, 8'h5A);
    wait_idle(0);

    repeat (4) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1, meaning SCK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en_transit  input  1  transfer request, sampled only in IDLE.
REQ-005 SHALL have port data  input  8  byte to transmit, captured at transfer start.
REQ-006 SHALL have port sck  output  1  SPI serial clock, mode 0 (idle low).
REQ-007 SHALL have port mosi  output  1  serial data out, MSB first.
REQ-008 SHALL have port cs  output  1  active-low chip select.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Function
REQ-011 SHALL implement states IDLE, TRANSFER, DONE.
REQ-012 IDLE SHALL hold cs=1, sck=0, mosi=0, busy=0.
REQ-013 In IDLE, a clk edge with en_transit=1 SHALL:
- latch data into an 8-bit shift register;
- set cs=0 and mosi=data[7];
- keep sck=0;
- clear the bit counter and divider counter;
- enter TRANSFER.
REQ-014 In TRANSFER, sck SHALL toggle every CLK_DIV clk cycles, the first rising edge coming CLK_DIV cycles after cs falls.
REQ-015 On each sck falling toggle with bit counter below 7, mosi SHALL take the next lower data bit and the bit counter SHALL increment.
REQ-016 On the 8th sck falling toggle, the FSM SHALL enter DONE, with sck=0 and mosi holding bit 0.
REQ-017 DONE SHALL last CLK_DIV cycles, then set cs=1 and mosi=0 and return to IDLE.
REQ-018 cs SHALL be low for 17*CLK_DIV... precisely 16*CLK_DIV+CLK_DIV cycles per byte, with exactly 8 sck rising edges while cs=0.
REQ-019 mosi SHALL be stable for CLK_DIV cycles before and after each sck rising edge.
REQ-020 en_transit asserted while busy=1 SHALL be ignored, with no queuing.
REQ-021 Changes on data after capture SHALL NOT affect the byte in progress.
REQ-022 en_transit held high continuously SHALL produce back-to-back transfers, with cs high for exactly 1 clk cycle between them and data re-captured each time.

Reset
REQ-023 Asserting reset=0 SHALL immediately, asynchronously force the following, aborting any transfer in progress:
- state IDLE;
- cs=1, sck=0, mosi=0, busy=0;
- counters and shift register to 0.
REQ-024 After reset deasserts, the first transfer SHALL start only on an edge that samples en_transit=1.

Verification
REQ-025 Single-byte transfer: CLK_DIV=1, data=8'hAA, en_transit pulsed high for 1 cycle at edge T. Required response:
- cs falls at T and rises at T+17;
- sck rises at T+1, T+3, ..., T+15;
- mosi sampled at those rises reads 1,0,1,0,1,0,1,0.
REQ-026 Request while busy: repeat REQ-025 and pulse en_transit again at T+12. Required response:
- the pulse is ignored, with no extra sck edges;
- cs stays high after T+17.
REQ-027 Data change mid-transfer: data=8'h3C at start, switched to 8'hFF at T+4. Required response: the captured stream is 0,0,1,1,1,1,0,0.
REQ-028 Continuous request: en_transit held high, data=8'h81. Required response:
- two consecutive frames, each reading 1,0,0,0,0,0,0,1;
- cs high exactly 1 cycle between frames.
REQ-029 Divided clock: CLK_DIV=4, data=8'h5A. Required response:
- sck half-period is 4 cycles;
- cs is low for 68 cycles;
- mosi reads 0,1,0,1,1,0,1,0.
REQ-030 Reset mid-transfer: assert reset=0 at T+6. Required response:
- cs=1, sck=0, mosi=0, busy=0 immediately, without waiting for a clk edge;
- after release, no activity until the next en_transit pulse.
